// File: rtl/context_update_if.sv
// rtl/context_update_if.sv - sample/result bundle for the JPEG-LS context update stage
// Optional member sample_cnt exists only when CU_SAMPLE_COUNT_EN is defined.
interface context_update_if;
  logic              en;
  logic [8:0]        Q;
  logic              C_sign;
  logic signed [8:0] Errval0;
  logic signed [8:0] Errval1;
  logic signed [8:0] Errval2;
  logic [8:0]        MErrval;
  logic [3:0]        k;
  logic [8:0]        Q_out;
  logic signed [7:0] C_Q_out;
  logic              en_out;
  logic              ready;
  logic              q_err;
`ifdef CU_SAMPLE_COUNT_EN
  logic [15:0]       sample_cnt;

  modport master (
    output en, Q, C_sign, Errval0, Errval1, Errval2,
    input  MErrval, k, Q_out, C_Q_out, en_out, ready, q_err, sample_cnt
  );

  modport slave (
    input  en, Q, C_sign, Errval0, Errval1, Errval2,
    output MErrval, k, Q_out, C_Q_out, en_out, ready, q_err, sample_cnt
  );
`else
  modport master (
    output en, Q, C_sign, Errval0, Errval1, Errval2,
    input  MErrval, k, Q_out, C_Q_out, en_out, ready, q_err
  );

  modport slave (
    input  en, Q, C_sign, Errval0, Errval1, Errval2,
    output MErrval, k, Q_out, C_Q_out, en_out, ready, q_err
  );
`endif
endinterface

// File: rtl/context_update.sv
// rtl/context_update.sv - JPEG-LS context statistics update (A/B/C/N), Golomb k and error mapping
// Optional sample counter output enabled by macro CU_SAMPLE_COUNT_EN.
module context_update (
  input  logic             clk,
  input  logic             reset,
  context_update_if.slave  bus
);

  localparam int unsigned NUM_CTX = 365;

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  state_t            state_q, state_d;
  logic [8:0]        init_cnt_q, init_cnt_d;
  logic              init_we;
  dir_t              last_dir_q, dir_d;

  logic [15:0]       a_mem [NUM_CTX];
  logic signed [7:0] b_mem [NUM_CTX];
  logic signed [7:0] c_mem [NUM_CTX];
  logic [6:0]        n_mem [NUM_CTX];

  logic              q_valid, run_en, upd_we;
  logic [8:0]        rd_idx;
  logic [15:0]       a_cur;
  logic signed [7:0] b_cur, c_cur;
  logic [6:0]        n_cur;
  logic signed [8:0] e_sel;
  logic [8:0]        abs_e;
  logic [3:0]        k_calc;
  logic signed [11:0] b_ext, n_cur_s, n_new_s, b_work;
  logic              low_bias;
  logic [8:0]        mer_calc;
  logic [15:0]       a_new;
  logic [6:0]        n_half, n_new;
  logic signed [7:0] c_new, b_new;

  logic [8:0]        merr_q;
  logic [3:0]        k_q;
  logic [8:0]        q_out_q;
  logic signed [7:0] c_out_q;
  logic              en_out_q, q_err_q;

  // Init sequencer: state register and init address counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Init sequencer: walk every context once, then run forever
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_we    = 1'b0;
    if (state_q == ST_INIT) begin
      init_we    = 1'b1;
      init_cnt_d = init_cnt_q + 9'd1;
      if (init_cnt_q == 9'(NUM_CTX - 1)) begin
        state_d    = ST_RUN;
        init_cnt_d = '0;
      end
    end
  end

  // Read the addressed context, derive k / mapped error / updated statistics
  always_comb begin
    run_en  = (state_q == ST_RUN) && bus.en;
    q_valid = (bus.Q < 9'(NUM_CTX));
    upd_we  = run_en && q_valid;
    rd_idx  = q_valid ? bus.Q : 9'd0;
    a_cur   = a_mem[rd_idx];
    b_cur   = b_mem[rd_idx];
    c_cur   = c_mem[rd_idx];
    n_cur   = n_mem[rd_idx];

    // Candidate chosen by whether C moved the last time and which way
    e_sel = bus.Errval0;
    if (bus.C_sign && last_dir_q == DIR_UP)   e_sel = bus.Errval1;
    if (bus.C_sign && last_dir_q == DIR_DOWN) e_sel = bus.Errval2;
    abs_e = e_sel[8] ? 9'(-e_sel) : 9'(e_sel);

    // Downward scan leaves the smallest satisfying k; 15 if none does
    k_calc = 4'd15;
    for (int i = 14; i >= 0; i--) begin
      if ((22'(n_cur) << i) >= 22'(a_cur)) k_calc = 4'(i);
    end

    b_ext    = 12'(b_cur);
    n_cur_s  = $signed({5'd0, n_cur});
    low_bias = (k_calc == 4'd0) && ((b_ext <<< 1) <= -n_cur_s);

    // 2E = {e[7:0],0} and -2E-1 = ~(2E) in 9 bits, so every mapping is a bit shuffle
    if (low_bias)
      mer_calc = e_sel[8] ? {~e_sel[7:0], 1'b0} : {e_sel[7:0], 1'b1};
    else
      mer_calc = e_sel[8] ? {~e_sel[7:0], 1'b1} : {e_sel[7:0], 1'b0};

    b_work = b_ext + 12'(e_sel);
    a_new  = a_cur + 16'(abs_e);
    n_half = n_cur;
    if (n_cur == 7'd64) begin
      a_new  = a_new >> 1;
      b_work = b_work >>> 1;
      n_half = 7'd32;
    end
    n_new   = n_half + 7'd1;
    n_new_s = $signed({5'd0, n_new});

    c_new = c_cur;
    dir_d = DIR_NONE;
    if (b_work <= -n_new_s) begin
      if (c_cur != 8'sh80) begin
        c_new = c_cur - 8'sd1;
        dir_d = DIR_DOWN;
      end
      b_work = b_work + n_new_s;
      if (b_work <= -n_new_s) b_work = 12'sd1 - n_new_s;
    end else if (b_work > 12'sd0) begin
      if (c_cur != 8'sd127) begin
        c_new = c_cur + 8'sd1;
        dir_d = DIR_UP;
      end
      b_work = b_work - n_new_s;
      if (b_work > 12'sd0) b_work = 12'sd0;
    end
    b_new = 8'(b_work);
  end

  // Context store: init defaults during INIT, write-back of the accepted sample during RUN
  always_ff @(posedge clk) begin
    if (init_we) begin
      a_mem[init_cnt_q] <= 16'd4;
      b_mem[init_cnt_q] <= 8'sd0;
      c_mem[init_cnt_q] <= 8'sd0;
      n_mem[init_cnt_q] <= 7'd1;
    end else if (upd_we) begin
      a_mem[bus.Q] <= a_new;
      b_mem[bus.Q] <= b_new;
      c_mem[bus.Q] <= c_new;
      n_mem[bus.Q] <= n_new;
    end
  end

  // Registered result: one cycle after an accepted sample, zero otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      merr_q     <= '0;
      k_q        <= '0;
      q_out_q    <= '0;
      c_out_q    <= '0;
      en_out_q   <= 1'b0;
      q_err_q    <= 1'b0;
      last_dir_q <= DIR_NONE;
    end else begin
      merr_q   <= '0;
      k_q      <= '0;
      q_out_q  <= '0;
      c_out_q  <= '0;
      en_out_q <= 1'b0;
      if (run_en) begin
        en_out_q <= 1'b1;
        q_out_q  <= bus.Q;
        if (q_valid) begin
          merr_q     <= mer_calc;
          k_q        <= k_calc;
          c_out_q    <= c_new;
          last_dir_q <= dir_d;
        end else begin
          q_err_q <= 1'b1;
        end
      end
    end
  end

`ifdef CU_SAMPLE_COUNT_EN
  logic [15:0] sample_cnt_q;

  // Saturating count of samples that reached a valid context
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sample_cnt_q <= '0;
    else if (upd_we && sample_cnt_q != 16'hFFFF)
      sample_cnt_q <= sample_cnt_q + 16'd1;
  end

  assign bus.sample_cnt = sample_cnt_q;
`endif

  assign bus.MErrval = merr_q;
  assign bus.k       = k_q;
  assign bus.Q_out   = q_out_q;
  assign bus.C_Q_out = c_out_q;
  assign bus.en_out  = en_out_q;
  assign bus.q_err   = q_err_q;
  assign bus.ready   = (state_q == ST_RUN);

endmodule

// File: tb/tb_context_update.sv
// tb/tb_context_update.sv - self-checking bench for context_update against a plain-arithmetic context model
module tb_context_update;
  logic clk = 1'b0;
  logic reset = 1'b1;

  context_update_if bus();

  context_update dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int mA[365], mB[365], mC[365], mN[365];
  int m_dir;
  bit m_qerr;
  int xm, xk, xq, xc;
  bit xqe;

  task automatic model_init(input bit clr_qerr);
    for (int i = 0; i < 365; i++) begin
      mA[i] = 4; mB[i] = 0; mC[i] = 0; mN[i] = 1;
    end
    m_dir = 0;
    if (clr_qerr) m_qerr = 0;
  endtask

  task automatic model_step(input int q, input bit cs, input int e0, input int e1, input int e2);
    int e, a, b, c, n, ae;
    if (q >= 365) begin
      m_qerr = 1;
      xm = 0; xk = 0; xq = q; xc = 0; xqe = m_qerr;
      return;
    end
    a = mA[q]; b = mB[q]; c = mC[q]; n = mN[q];
    if (cs && m_dir == 1) e = e1;
    else if (cs && m_dir == -1) e = e2;
    else e = e0;
    xk = 0;
    while (xk < 15 && (n << xk) < a) xk++;
    if (xk == 0 && 2 * b <= -n) xm = (e >= 0) ? 2 * e + 1 : -2 * (e + 1);
    else xm = (e >= 0) ? 2 * e : -2 * e - 1;
    ae = (e < 0) ? -e : e;
    b = b + e;
    a = (a + ae) % 65536;
    if (n == 64) begin
      a = a / 2;
      b = (b < 0) ? -((-b + 1) / 2) : b / 2;
      n = 32;
    end
    n = n + 1;
    m_dir = 0;
    if (b <= -n) begin
      if (c > -128) begin c = c - 1; m_dir = -1; end
      b = b + n;
      if (b <= -n) b = -n + 1;
    end else if (b > 0) begin
      if (c < 127) begin c = c + 1; m_dir = 1; end
      b = b - n;
      if (b > 0) b = 0;
    end
    mA[q] = a; mB[q] = b; mC[q] = c; mN[q] = n;
    xq = q; xc = c; xqe = m_qerr;
  endtask

  task automatic drive(input bit e, input int q, input bit cs, input int e0, input int e1, input int e2);
    @(negedge clk);
    bus.en      = e;
    bus.Q       = 9'(q);
    bus.C_sign  = cs;
    bus.Errval0 = 9'(e0);
    bus.Errval1 = 9'(e1);
    bus.Errval2 = 9'(e2);
    @(posedge clk);
    #1;
  endtask

  task automatic run_init(input int pulse_at, output int ready_at, output bit saw_out);
    ready_at = -1;
    saw_out  = 1'b0;
    for (int c = 1; c <= 1000 && ready_at < 0; c++) begin
      drive(c == pulse_at, 10, 1'b0, 5, 5, 5);
      if (bus.en_out !== 1'b0) saw_out = 1'b1;
      if (bus.ready === 1'b1) ready_at = c;
    end
  endtask

  task automatic test_reset;
    bus.en = 1'b0; bus.Q = '0; bus.C_sign = 1'b0;
    bus.Errval0 = '0; bus.Errval1 = '0; bus.Errval2 = '0;
    reset = 1'b1;
    #23;
    n_cmp++;
    if ({bus.ready, bus.en_out, bus.q_err, bus.MErrval, bus.k, bus.Q_out, bus.C_Q_out} !== '0) begin
      n_err++;
      $display("FAIL reset_state: ready=%b en_out=%b q_err=%b MErrval=%0d k=%0d Q_out=%0d C=%0d, required all zero",
               bus.ready, bus.en_out, bus.q_err, bus.MErrval, bus.k, bus.Q_out, bus.C_Q_out);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    model_init(1'b1);
  endtask

  task automatic test_init;
    int rdy;
    bit saw;
    run_init(100, rdy, saw);
    n_cmp++;
    if (rdy !== 365) begin
      n_err++;
      $display("FAIL init_ready_cycle: ready at cycle %0d, required 365", rdy);
    end
    n_cmp++;
    if (saw !== 1'b0) begin
      n_err++;
      $display("FAIL init_en_ignored: en_out seen during init, required none");
    end
  endtask

  task automatic test_directed;
    int dq[3]  = '{10, 10, 20};
    bit dcs[3] = '{1'b0, 1'b1, 1'b0};
    int d0[3]  = '{5, 7, -3};
    int d1[3]  = '{0, 6, 0};
    int d2[3]  = '{0, 8, 0};
    int ek[3]  = '{2, 3, 2};
    int em[3]  = '{10, 12, 5};
    int ec[3]  = '{1, 2, -1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, dq[i], dcs[i], d0[i], d1[i], d2[i]);
      model_step(dq[i], dcs[i], d0[i], d1[i], d2[i]);
      n_cmp++;
      if (bus.en_out !== 1'b1 || bus.MErrval !== 9'(xm) || bus.k !== 4'(xk) ||
          bus.Q_out !== 9'(xq) || bus.C_Q_out !== 8'(xc) || bus.q_err !== xqe) begin
        n_err++;
        $display("FAIL directed_model[%0d]: en_out=%b M=%0d k=%0d Q=%0d C=%0d qe=%b, required 1 M=%0d k=%0d Q=%0d C=%0d qe=%b",
                 i, bus.en_out, bus.MErrval, bus.k, bus.Q_out, bus.C_Q_out, bus.q_err, xm, xk, xq, xc, xqe);
      end
      n_cmp++;
      if (bus.k !== 4'(ek[i]) || bus.MErrval !== 9'(em[i]) || bus.C_Q_out !== 8'(ec[i])) begin
        n_err++;
        $display("FAIL directed_const[%0d]: k=%0d M=%0d C=%0d, required k=%0d M=%0d C=%0d",
                 i, bus.k, bus.MErrval, bus.C_Q_out, ek[i], em[i], ec[i]);
      end
    end
    drive(1'b0, 10, 1'b0, 0, 0, 0);
    n_cmp++;
    if ({bus.en_out, bus.MErrval, bus.k, bus.Q_out, bus.C_Q_out, bus.q_err} !== '0) begin
      n_err++;
      $display("FAIL idle_zero: en_out=%b M=%0d k=%0d Q=%0d C=%0d qe=%b, required all zero",
               bus.en_out, bus.MErrval, bus.k, bus.Q_out, bus.C_Q_out, bus.q_err);
    end
  endtask

  task automatic test_halving;
    bit cs;
    for (int i = 1; i <= 65; i++) begin
      cs = 1'($urandom_range(0, 1));
      drive(1'b1, 30, cs, 0, 0, 0);
      model_step(30, cs, 0, 0, 0);
      n_cmp++;
      if (bus.en_out !== 1'b1 || bus.MErrval !== 9'(xm) || bus.k !== 4'(xk) || bus.C_Q_out !== 8'(xc)) begin
        n_err++;
        $display("FAIL halving[%0d]: M=%0d k=%0d C=%0d, required M=%0d k=%0d C=%0d",
                 i, bus.MErrval, bus.k, bus.C_Q_out, xm, xk, xc);
      end
    end
    n_cmp++;
    if (bus.k !== 4'd0 || bus.MErrval !== 9'd0) begin
      n_err++;
      $display("FAIL halving_65th: k=%0d M=%0d, required k=0 M=0", bus.k, bus.MErrval);
    end
    drive(1'b0, 0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_clamp;
    int ev;
    bit cs;
    for (int i = 0; i < 410; i++) begin
      ev = (i < 140) ? 100 : -100;
      cs = 1'($urandom_range(0, 1));
      drive(1'b1, 5, cs, ev, ev, ev);
      model_step(5, cs, ev, ev, ev);
      n_cmp++;
      if (bus.MErrval !== 9'(xm) || bus.k !== 4'(xk) || bus.C_Q_out !== 8'(xc)) begin
        n_err++;
        $display("FAIL clamp[%0d]: M=%0d k=%0d C=%0d, required M=%0d k=%0d C=%0d",
                 i, bus.MErrval, bus.k, bus.C_Q_out, xm, xk, xc);
      end
      if (i == 139) begin
        n_cmp++;
        if (bus.C_Q_out !== 8'sd127) begin
          n_err++;
          $display("FAIL clamp_top: C=%0d, required 127", bus.C_Q_out);
        end
      end
    end
    n_cmp++;
    if (bus.C_Q_out !== 8'sh80) begin
      n_err++;
      $display("FAIL clamp_bottom: C=%0d, required -128", bus.C_Q_out);
    end
    drive(1'b0, 0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    bit e, cs;
    int q, e0, e1, e2, r;
    for (int i = 0; i < 300; i++) begin
      r  = int'($urandom_range(0, 99));
      e  = (r >= 10);
      q  = (r >= 95) ? int'($urandom_range(365, 511)) : int'($urandom_range(0, 7));
      cs = 1'($urandom_range(0, 1));
      e0 = int'($urandom_range(0, 511)) - 256;
      e1 = int'($urandom_range(0, 511)) - 256;
      e2 = int'($urandom_range(0, 511)) - 256;
      drive(e, q, cs, e0, e1, e2);
      if (e) begin
        model_step(q, cs, e0, e1, e2);
      end else begin
        xm = 0; xk = 0; xq = 0; xc = 0; xqe = m_qerr;
      end
      n_cmp++;
      if (bus.en_out !== e || bus.MErrval !== 9'(xm) || bus.k !== 4'(xk) ||
          bus.Q_out !== 9'(xq) || bus.C_Q_out !== 8'(xc) || bus.q_err !== xqe) begin
        n_err++;
        $display("FAIL b2b[%0d]: en_out=%b M=%0d k=%0d Q=%0d C=%0d qe=%b, required %b M=%0d k=%0d Q=%0d C=%0d qe=%b",
                 i, bus.en_out, bus.MErrval, bus.k, bus.Q_out, bus.C_Q_out, bus.q_err, e, xm, xk, xq, xc, xqe);
      end
    end
    drive(1'b0, 0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_qerr_reset;
    int rdy;
    bit saw;
    drive(1'b1, 400, 1'b0, 9, 9, 9);
    model_step(400, 1'b0, 9, 9, 9);
    n_cmp++;
    if (bus.q_err !== 1'b1 || bus.en_out !== 1'b1 || bus.MErrval !== 9'd0 || bus.k !== 4'd0 || bus.Q_out !== 9'd400) begin
      n_err++;
      $display("FAIL qerr_pulse: qe=%b en_out=%b M=%0d k=%0d Q=%0d, required 1 1 0 0 400",
               bus.q_err, bus.en_out, bus.MErrval, bus.k, bus.Q_out);
    end
    drive(1'b0, 0, 1'b0, 0, 0, 0);
    n_cmp++;
    if (bus.q_err !== 1'b1 || bus.en_out !== 1'b0) begin
      n_err++;
      $display("FAIL qerr_sticky: qe=%b en_out=%b, required 1 0", bus.q_err, bus.en_out);
    end
    @(negedge clk);
    bus.en = 1'b1; bus.Q = 9'd10; bus.C_sign = 1'b0;
    bus.Errval0 = 9'sd50; bus.Errval1 = 9'sd50; bus.Errval2 = 9'sd50;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.ready !== 1'b0 || bus.en_out !== 1'b0 || bus.q_err !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: ready=%b en_out=%b qe=%b, required 0 0 0", bus.ready, bus.en_out, bus.q_err);
    end
    @(posedge clk); #2;
    bus.en = 1'b0;
    reset = 1'b0;
    model_init(1'b1);
    run_init(0, rdy, saw);
    n_cmp++;
    if (rdy !== 365 || saw !== 1'b0) begin
      n_err++;
      $display("FAIL reinit: ready at cycle %0d en_out_seen=%b, required 365 and 0", rdy, saw);
    end
    drive(1'b1, 10, 1'b0, 5, 0, 0);
    model_step(10, 1'b0, 5, 0, 0);
    n_cmp++;
    if (bus.k !== 4'd2 || bus.MErrval !== 9'd10 || bus.C_Q_out !== 8'sd1 || bus.q_err !== 1'b0 ||
        bus.MErrval !== 9'(xm)) begin
      n_err++;
      $display("FAIL post_reinit: k=%0d M=%0d C=%0d qe=%b, required k=2 M=10 C=1 qe=0",
               bus.k, bus.MErrval, bus.C_Q_out, bus.q_err);
    end
    drive(1'b0, 0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    test_reset;
    test_init;
    test_directed;
    test_halving;
    test_clamp;
    test_back_to_back;
    test_qerr_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
